device_input_ctrl: RTL
======================

Name: device_input_ctrl

Overview:
Input-side counterpart to the board's LED/seven-segment output path: conditions the raw on-board switches and push buttons before the Bridge reads them. Each of the 24 switch and 5 button inputs is synchronized into clk_i and debounced. The block produces one-cycle press pulses and latches sticky press events. It also provides a word-wide read port through which the Bridge returns switch/button state to the CPU on rData.

Parameters:
DEBOUNCE_CYCLES, 20000, consecutive clk_i edges an input must differ from its stable value before the stable value updates; legal range 1..2^CNT_W-1.
CNT_W, 16, width of each per-bit debounce counter.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  asynchronous reset, active-high.
device_sw  input  24  raw switch pins, asynchronous.
device_button  input  5  raw button pins, asynchronous, 1 = pressed.
rd_en  input  1  Bridge read strobe for this block.
rd_sel  input  2  read register select.
rdata  output  32  read data, combinational from rd_sel and internal registers.
sw_stable  output  24  debounced switch levels.
btn_stable  output  5  debounced button levels.
btn_press_pulse  output  5  one-cycle pulse on each debounced 0->1 button transition.
btn_event_pending  output  1  OR of the sticky event bits.

Behaviour:
- Reset (async, rst_i=1):
  - Sync flops, stable regs, counters, btn_event, btn_press_pulse and btn_event_pending all clear to 0.
  - rdata follows the read mux, so it is 0 for all rd_sel values.
- Synchronizer: two flops per input bit (29 bits). sync2 is valid 2 edges after a pin change.
- Per-bit debouncer (29 identical instances):
  - if sync2 == stable: counter <= 0.
  - else if counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - else: counter <= counter+1.
  - Result: stable updates on the DEBOUNCE_CYCLES-th consecutive edge with sync2 != stable. Pin-to-stable latency is exactly DEBOUNCE_CYCLES+2 edges.
  - Any return to the stable value before that point discards the partial count; glitches are never propagated.
  - DEBOUNCE_CYCLES=1 gives a latency of 3 edges.
- Press pulse: btn_press_pulse[i] = 1 for exactly one cycle, registered, on the edge after btn_stable[i] goes 0->1. No pulse on release.
- Sticky events, btn_event[4:0]:
  - bit i sets on btn_press_pulse[i].
  - all bits clear on the edge where rd_en=1 and rd_sel=2'b10 (read-to-clear).
  - If set and clear occur for the same bit on the same edge, set wins, so no press is lost.
- btn_event_pending = |btn_event.
- Read mux, same cycle, no wait states:
  - rd_sel=00: {8'h0, sw_stable}
  - rd_sel=01: {27'h0, btn_stable}
  - rd_sel=10: {27'h0, btn_event}; this is the value before the clear.
  - rd_sel=11: 32'h0.
  - rd_en affects only the clear side effect; rdata is driven regardless of rd_en.
- Reset mid-debounce discards all progress. Inputs already asserted when reset releases require a full DEBOUNCE_CYCLES+2 before they appear on the stable outputs.
- Multiple bits changing together debounce independently; each has its own counter.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8.
- Reset: hold rst_i=1 with device_sw=24'hFFFFFF. sw_stable=0 and rdata=0 for every rd_sel. Release rst_i: sw_stable becomes 24'hFFFFFF exactly 10 edges later.
- Glitch rejection: pulse device_button[2] high for 6 cycles, then low. btn_stable stays 0, no press pulse, btn_event=0.
- Clean press: hold device_button[0] high. btn_stable[0] rises at edge 10. btn_press_pulse[0] is high for exactly 1 cycle, then btn_event=5'b00001 and btn_event_pending=1. Releasing the button gives no pulse.
- Read-to-clear: with btn_event=5'b00101, drive rd_en=1, rd_sel=2'b10. rdata=32'h5 in that cycle and btn_event=0 on the next cycle. Reading with rd_sel=01 leaves btn_event unchanged.
- Set/clear collision: schedule a read-clear on the same edge as a btn_press_pulse[4]. Afterwards btn_event=5'b10000 and pending=1.
- Switch readback: set device_sw=24'hA5C3F0 and wait 10 edges. rd_sel=00 returns 32'h00A5C3F0; rd_sel=11 returns 32'h0.

Source files
------------

// File: rtl/device_input_ctrl.sv
// Switch/button conditioning: 2-flop sync, per-bit debounce, press pulses,
// sticky press events and a word-wide read port for the Bridge.
module device_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int CNT_W           = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [23:0] device_sw,
   input  logic [4:0]  device_button,
   input  logic        rd_en,
   input  logic [1:0]  rd_sel,
   output logic [31:0] rdata,
   output logic [23:0] sw_stable,
   output logic [4:0]  btn_stable,
   output logic [4:0]  btn_press_pulse,
   output logic        btn_event_pending
);

   localparam int N = 29;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N-1:0]     sync1;
   logic [N-1:0]     sync2;
   logic [N-1:0]     stable;
   logic [CNT_W-1:0] cnt [N];
   logic [4:0]       btn_d;
   logic [4:0]       btn_event;
   logic             clr;

   assign clr = rd_en && (rd_sel == 2'b10);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1           <= '0;
         sync2           <= '0;
         stable          <= '0;
         btn_d           <= '0;
         btn_press_pulse <= '0;
         btn_event       <= '0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         sync1 <= {device_button, device_sw};
         sync2 <= sync1;
         // A return to the stable level discards any partial count.
         for (int i = 0; i < N; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         btn_d           <= stable[28:24];
         btn_press_pulse <= stable[28:24] & ~btn_d;
         // Set wins over read-to-clear so no press is lost.
         btn_event       <= (clr ? 5'b0 : btn_event) | btn_press_pulse;
      end
   end

   assign sw_stable         = stable[23:0];
   assign btn_stable        = stable[28:24];
   assign btn_event_pending = |btn_event;

   always_comb begin
      rdata = 32'h0;
      unique case (rd_sel)
         2'b00:   rdata = {8'h0, sw_stable};
         2'b01:   rdata = {27'h0, btn_stable};
         2'b10:   rdata = {27'h0, btn_event};
         default: rdata = 32'h0;
      endcase
   end

endmodule
